// File: rtl/microcode_pkg.sv
// Shared types and microword layout helpers for the microcode sequencer.
package microcode_pkg;

  localparam int CTRL_W_D = 32;
  localparam int ADDR_W_D = 8;
  localparam int OP_W_D   = 6;

  function automatic int uw_f(input int cw, input int aw);
    return cw + aw + 2;
  endfunction

  function automatic int tgt_lsb_f(input int cw);
    return cw;
  endfunction

  function automatic int jmp_bit_f(input int cw, input int aw);
    return cw + aw;
  endfunction

  function automatic int eos_bit_f(input int cw, input int aw);
    return cw + aw + 1;
  endfunction

  // Microword {eos, jmp, target, ctrl}, MSB first, at default widths
  localparam int CTRL_LSB = 0;
  localparam int TGT_LSB  = CTRL_W_D;
  localparam int JMP_BIT  = CTRL_W_D + ADDR_W_D;
  localparam int EOS_BIT  = JMP_BIT + 1;
  localparam int UW_D     = EOS_BIT + 1;

  localparam logic [OP_W_D-1:0] HALT_OP = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } seq_state_t;

endpackage

// File: rtl/microcode_store.sv
// Code RAM plus opcode dispatch table, one write port, async reads.
module microcode_store
  import microcode_pkg::*;
#(
  parameter int CTRL_W = 32,
  parameter int ADDR_W = 8,
  parameter int OP_W   = 6,
  parameter int UW     = uw_f(CTRL_W, ADDR_W)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic              i_sel,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [UW-1:0]     i_data,
  input  logic [ADDR_W-1:0] i_raddr,
  input  logic [OP_W-1:0]   i_op,
  output logic [UW-1:0]     o_word,
  output logic              o_vld,
  output logic [ADDR_W-1:0] o_daddr
);

  logic [UW-1:0]     r_code [2**ADDR_W];
  logic [ADDR_W-1:0] r_dadr [2**OP_W];
  logic [2**OP_W-1:0] r_vld;

  logic [OP_W-1:0] w_wop;
  assign w_wop = i_addr[OP_W-1:0];

  always_ff @(posedge i_clk) begin
    if (i_we && !i_sel) begin
      r_code[i_addr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_we && i_sel) begin
      r_dadr[w_wop] <= i_data[ADDR_W-1:0];
    end
  end

  // Only the valid bits need reset; stale addresses are harmless
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld <= '0;
    end else if (i_we && i_sel) begin
      r_vld[w_wop] <= i_data[ADDR_W];
    end
  end

  assign o_word  = r_code[i_raddr];
  assign o_vld   = r_vld[i_op];
  assign o_daddr = r_dadr[i_op];

endmodule

// File: rtl/microcode_seq.sv
// Microcode sequencer: opcode dispatch, word-per-cycle issue, jumps,
// stall, HALT and bad-opcode reporting.
module microcode_seq
  import microcode_pkg::*;
#(
  parameter int CTRL_W = 32,
  parameter int ADDR_W = 8,
  parameter int OP_W   = 6,
  parameter int UW     = uw_f(CTRL_W, ADDR_W)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [OP_W-1:0]   i_opcode,
  input  logic              i_stall,
  input  logic              i_prog_we,
  input  logic              i_prog_sel,
  input  logic [ADDR_W-1:0] i_prog_addr,
  input  logic [UW-1:0]     i_prog_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_eos,
  output logic              o_busy,
  output logic              o_halted,
  output logic              o_bad_op,
  output logic [ADDR_W-1:0] o_upc
);

  localparam int L_TGT = tgt_lsb_f(CTRL_W);
  localparam int L_JMP = jmp_bit_f(CTRL_W, ADDR_W);
  localparam int L_EOS = eos_bit_f(CTRL_W, ADDR_W);
  localparam logic [ADDR_W-1:0] ONE = 1;

  seq_state_t r_state, w_state;
  logic [ADDR_W-1:0] r_upc, w_upc;
  logic [CTRL_W-1:0] r_ctrl, w_ctrl;
  logic [ADDR_W-1:0] r_tgt, w_tgt;
  logic r_eos, w_eos;
  logic r_jmp, w_jmp;
  logic r_busy, w_busy;
  logic r_halted, w_halted;
  logic r_bad, w_bad;

  logic [UW-1:0]     w_word;
  logic              w_dvld;
  logic [ADDR_W-1:0] w_daddr;
  logic [ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0] w_raddr;
  logic w_we;
  logic w_live, w_step, w_take;
  logic w_hgo, w_bgo, w_lgo, w_end;

  assign w_we = i_prog_we && (r_state == S_IDLE);

  microcode_store #(
    .CTRL_W(CTRL_W),
    .ADDR_W(ADDR_W),
    .OP_W  (OP_W),
    .UW    (UW)
  ) u_store (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_we   (w_we),
    .i_sel  (i_prog_sel),
    .i_addr (i_prog_addr),
    .i_data (i_prog_data),
    .i_raddr(w_raddr),
    .i_op   (i_opcode),
    .o_word (w_word),
    .o_vld  (w_dvld),
    .o_daddr(w_daddr)
  );

  assign w_seq   = r_jmp ? r_tgt : r_upc + ONE;
  assign w_live  = !i_stall && (r_state != S_HALT);
  assign w_step  = w_live && (r_state == S_RUN) && !r_eos;
  assign w_take  = w_live && !w_step && i_start;
  assign w_hgo   = w_take && (i_opcode == {OP_W{1'b1}});
  assign w_bgo   = w_take && !w_hgo && !w_dvld;
  assign w_lgo   = w_take && !w_hgo && w_dvld;
  assign w_end   = w_live && !w_step && !i_start;
  assign w_raddr = w_step ? w_seq : w_daddr;

  always_comb begin
    w_state  = r_state;
    w_upc    = r_upc;
    w_ctrl   = r_ctrl;
    w_tgt    = r_tgt;
    w_eos    = r_eos;
    w_jmp    = r_jmp;
    w_busy   = r_busy;
    w_halted = r_halted;
    w_bad    = 1'b0;
    unique case (1'b1)
      w_step, w_lgo: begin
        w_state = S_RUN;
        w_upc   = w_raddr;
        w_ctrl  = w_word[CTRL_W-1:0];
        w_tgt   = w_word[L_TGT +: ADDR_W];
        w_jmp   = w_word[L_JMP];
        w_eos   = w_word[L_EOS];
        w_busy  = 1'b1;
      end
      w_hgo, w_bgo, w_end: begin
        w_state  = w_hgo ? S_HALT : S_IDLE;
        w_halted = r_halted | w_hgo;
        w_bad    = w_bgo;
        w_ctrl   = '0;
        w_eos    = 1'b0;
        w_jmp    = 1'b0;
        w_busy   = 1'b0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_upc    <= '0;
      r_ctrl   <= '0;
      r_tgt    <= '0;
      r_eos    <= 1'b0;
      r_jmp    <= 1'b0;
      r_busy   <= 1'b0;
      r_halted <= 1'b0;
      r_bad    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_upc    <= w_upc;
      r_ctrl   <= w_ctrl;
      r_tgt    <= w_tgt;
      r_eos    <= w_eos;
      r_jmp    <= w_jmp;
      r_busy   <= w_busy;
      r_halted <= w_halted;
      r_bad    <= w_bad;
    end
  end

  assign o_ctrl   = r_ctrl;
  assign o_eos    = r_eos;
  assign o_busy   = r_busy;
  assign o_halted = r_halted;
  assign o_bad_op = r_bad;
  assign o_upc    = r_upc;

endmodule

// File: tb/tb_microcode_seq.sv
// Directed bench for microcode_seq with a memory-level reference model
// checked every cycle, plus literal spot checks.
module tb_microcode_seq;

  logic        clk;
  logic        i_rst;
  logic        i_start;
  logic [5:0]  i_opcode;
  logic        i_stall;
  logic        i_prog_we;
  logic        i_prog_sel;
  logic [7:0]  i_prog_addr;
  logic [41:0] i_prog_data;
  logic [31:0] o_ctrl;
  logic        o_eos;
  logic        o_busy;
  logic        o_halted;
  logic        o_bad_op;
  logic [7:0]  o_upc;

  microcode_seq dut (
    .i_clk      (clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_opcode   (i_opcode),
    .i_stall    (i_stall),
    .i_prog_we  (i_prog_we),
    .i_prog_sel (i_prog_sel),
    .i_prog_addr(i_prog_addr),
    .i_prog_data(i_prog_data),
    .o_ctrl     (o_ctrl),
    .o_eos      (o_eos),
    .o_busy     (o_busy),
    .o_halted   (o_halted),
    .o_bad_op   (o_bad_op),
    .o_upc      (o_upc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: tables as programmed, and where execution currently is.
  // Outputs follow from the word stored at the current address.
  logic [41:0] m_code [256];
  bit          m_vld  [64];
  logic [7:0]  m_da   [64];
  int          m_mode;
  logic [7:0]  m_upc;
  bit          m_busy, m_halt, m_bad;

  initial begin
    for (int i = 0; i < 256; i++) m_code[i] = '0;
    for (int i = 0; i < 64; i++) begin
      m_vld[i] = 0;
      m_da[i]  = '0;
    end
    m_mode = 0; m_upc = '0; m_busy = 0; m_halt = 0; m_bad = 0;
  end

  task automatic model_step();
    logic [41:0] w;
    bit wr;
    if (i_rst) begin
      for (int i = 0; i < 64; i++) m_vld[i] = 0;
      m_mode = 0; m_upc = '0; m_busy = 0; m_halt = 0; m_bad = 0;
    end else begin
      wr = i_prog_we && (m_mode == 0);
      m_bad = 0;
      if (!i_stall && m_mode != 2) begin
        w = m_code[m_upc];
        if (m_mode == 1 && !w[41]) begin
          m_upc = w[40] ? w[39:32] : m_upc + 8'd1;
        end else if (i_start) begin
          if (i_opcode == 6'h3F) begin
            m_mode = 2; m_halt = 1; m_busy = 0;
          end else if (!m_vld[i_opcode]) begin
            m_mode = 0; m_bad = 1; m_busy = 0;
          end else begin
            m_mode = 1; m_busy = 1; m_upc = m_da[i_opcode];
          end
        end else begin
          m_mode = 0; m_busy = 0;
        end
      end
      if (wr) begin
        if (i_prog_sel) begin
          m_vld[i_prog_addr[5:0]] = i_prog_data[8];
          m_da[i_prog_addr[5:0]]  = i_prog_data[7:0];
        end else begin
          m_code[i_prog_addr] = i_prog_data;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    logic [41:0] w;
    model_step();
    #1;
    w = m_code[m_upc];
    chk("m_busy", 64'(o_busy), 64'(m_busy));
    chk("m_halted", 64'(o_halted), 64'(m_halt));
    chk("m_bad_op", 64'(o_bad_op), 64'(m_bad));
    chk("m_upc", 64'(o_upc), 64'(m_upc));
    chk("m_ctrl", 64'(o_ctrl), m_busy ? 64'(w[31:0]) : 64'd0);
    chk("m_eos", 64'(o_eos), m_busy ? 64'(w[41]) : 64'd0);
  end

  task automatic cyc(input logic rst, input logic st, input logic [5:0] op,
                     input logic stl, input logic we, input logic sel,
                     input logic [7:0] a, input logic [41:0] d);
    @(negedge clk);
    i_rst = rst; i_start = st; i_opcode = op; i_stall = stl;
    i_prog_we = we; i_prog_sel = sel; i_prog_addr = a; i_prog_data = d;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cyc(0, 0, 6'h0, 0, 0, 0, 8'h0, '0);
  endtask

  task automatic go(input logic [5:0] op);
    cyc(0, 1, op, 0, 0, 0, 8'h0, '0);
  endtask

  task automatic pcode(input logic [7:0] a, input logic e, input logic j,
                       input logic [7:0] t, input logic [31:0] c);
    cyc(0, 0, 6'h0, 0, 1, 0, a, {e, j, t, c});
  endtask

  task automatic pdisp(input logic [5:0] op, input logic [7:0] a,
                       input logic v);
    cyc(0, 0, 6'h0, 0, 1, 1, {2'b00, op}, {33'd0, v, a});
  endtask

  initial begin
    i_rst = 1; i_start = 0; i_opcode = '0; i_stall = 0;
    i_prog_we = 0; i_prog_sel = 0; i_prog_addr = '0; i_prog_data = '0;
    cyc(1, 0, 6'h0, 0, 0, 0, 8'h0, '0);
    cyc(1, 0, 6'h0, 0, 0, 0, 8'h0, '0);
    chk("rst_ctrl", 64'(o_ctrl), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_upc", 64'(o_upc), 64'd0);
    chk("rst_halted", 64'(o_halted), 64'd0);

    go(6'h00);
    chk("bad_pulse", 64'(o_bad_op), 64'd1);
    chk("bad_busy", 64'(o_busy), 64'd0);
    idle();
    chk("bad_clear", 64'(o_bad_op), 64'd0);

    for (int i = 0; i < 4; i++) pcode(8'(i), i == 3, 0, 8'h0, 32'h318);
    pdisp(6'h23, 8'h00, 1);
    pcode(8'h10, 0, 1, 8'h40, 32'hA1);
    pcode(8'h40, 1, 0, 8'h00, 32'hB2);
    pcode(8'h41, 1, 1, 8'h10, 32'hC3);
    pdisp(6'h01, 8'h10, 1);
    pdisp(6'h02, 8'h41, 1);

    go(6'h23);
    for (int k = 1; k <= 4; k++) begin
      chk("lw_ctrl", 64'(o_ctrl), 64'h318);
      chk("lw_eos", 64'(o_eos), 64'(k == 4));
      if (k < 4) idle();
    end
    idle();
    chk("lw_busy_drop", 64'(o_busy), 64'd0);

    go(6'h01);
    chk("jmp_upc0", 64'(o_upc), 64'h10);
    idle();
    chk("jmp_upc1", 64'(o_upc), 64'h40);
    chk("jmp_ctrl1", 64'(o_ctrl), 64'hB2);
    idle();
    chk("jmp_idle", 64'(o_busy), 64'd0);

    go(6'h23);
    idle();
    chk("stl_pre", 64'(o_upc), 64'h01);
    cyc(0, 0, 6'h0, 1, 0, 0, 8'h0, '0);
    cyc(0, 1, 6'h01, 1, 0, 0, 8'h0, '0);
    cyc(0, 0, 6'h0, 1, 0, 0, 8'h0, '0);
    chk("stl_hold_upc", 64'(o_upc), 64'h01);
    chk("stl_hold_ctrl", 64'(o_ctrl), 64'h318);
    idle();
    chk("stl_resume", 64'(o_upc), 64'h02);
    idle();
    chk("stl_eos", 64'(o_eos), 64'd1);
    idle();
    chk("stl_end", 64'(o_busy), 64'd0);

    go(6'h23);
    go(6'h3F);
    chk("run_start_ign", 64'(o_halted), 64'd0);
    pdisp(6'h05, 8'h40, 1);
    idle();
    chk("b2b_eos", 64'(o_eos), 64'd1);
    go(6'h02);
    chk("b2b_upc", 64'(o_upc), 64'h41);
    chk("b2b_busy", 64'(o_busy), 64'd1);
    chk("b2b_ctrl", 64'(o_ctrl), 64'hC3);
    idle();
    chk("eos_wins", 64'(o_busy), 64'd0);

    go(6'h05);
    chk("run_prog_drop", 64'(o_bad_op), 64'd1);
    pdisp(6'h06, 8'h40, 1);
    go(6'h06);
    chk("prog_visible", 64'(o_upc), 64'h40);
    idle();

    go(6'h3F);
    chk("halt_set", 64'(o_halted), 64'd1);
    pdisp(6'h07, 8'h40, 1);
    go(6'h23);
    chk("halt_busy", 64'(o_busy), 64'd0);
    cyc(1, 0, 6'h0, 0, 0, 0, 8'h0, '0);
    chk("halt_rst", 64'(o_halted), 64'd0);
    go(6'h23);
    chk("rst_vld_clr", 64'(o_bad_op), 64'd1);
    idle();
    go(6'h07);
    chk("halt_prog_drop", 64'(o_bad_op), 64'd1);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
